// File: rtl/data_mem_ctrl.sv
// Data-side memory subsystem: word RAM plus an MMIO block holding GPIO,
// a free-running cycle counter and a compare timer with interrupt flag.
// Loads are combinational; every write lands on the rising clock edge.
module data_mem_ctrl #(
    parameter int          DEPTH_LOG2 = 11,
    parameter logic [31:0] DM_BASE    = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h1002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rena,
    input  logic        wena,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Byte lane bits are ignored: every access is a full word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    logic [31:0] mem_q [0:DEPTH-1];

    logic [15:0] gpio_q,  gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q,   cmp_d;
    logic [31:0] cnt_q,   cnt_d;
    logic        en_q,    en_d;
    logic        irq_q,   irq_d;
    logic        reload_q, reload_d;

    logic                  in_ram, in_mmio, mmio_hit;
    logic [5:0]            woff;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  hit_gpio, hit_cycle, hit_cmp, hit_ctrl, hit_cnt;
    logic                  match;

    // Region and register decode; RAM aliases across its whole 64KB window.
    always_comb begin
        in_ram    = (addr[31:16] == DM_BASE[31:16]);
        in_mmio   = (addr[31:8]  == MMIO_BASE[31:8]);
        woff      = addr[7:2];
        ram_idx   = addr[DEPTH_LOG2+1:2];
        hit_gpio  = in_mmio && (woff == 6'd0);
        hit_cycle = in_mmio && (woff == 6'd1);
        hit_cmp   = in_mmio && (woff == 6'd2);
        hit_ctrl  = in_mmio && (woff == 6'd3);
        hit_cnt   = in_mmio && (woff == 6'd4);
        mmio_hit  = hit_gpio | hit_cycle | hit_cmp | hit_ctrl | hit_cnt;
        bus_err   = (rena | wena) & ~(in_ram | mmio_hit);
    end

    // Load data mux; reflects state before any same-cycle store.
    always_comb begin
        rdata = 32'd0;
        if (rena) begin
            if (in_ram)         rdata = mem_q[ram_idx];
            else if (hit_gpio)  rdata = {16'd0, gpio_q};
            else if (hit_cycle) rdata = cycle_q;
            else if (hit_cmp)   rdata = cmp_q;
            else if (hit_ctrl)  rdata = {29'd0, reload_q, irq_q, en_q};
            else if (hit_cnt)   rdata = cnt_q;
        end
    end

    // RAM store; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wena && in_ram && !rst) mem_q[ram_idx] <= wdata;
    end

    // Next-state for MMIO registers. Timer effects are applied first, then CPU
    // writes override them, except that an IRQ set wins over its W1C clear.
    always_comb begin
        gpio_d   = gpio_q;
        cycle_d  = cycle_q + 32'd1;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        irq_d    = irq_q;
        reload_d = reload_q;
        match    = en_q && (cnt_q == cmp_q);

        if (en_q) begin
            if (!match)        cnt_d = cnt_q + 32'd1;
            else if (reload_q) cnt_d = 32'd0;
            else               en_d  = 1'b0;
        end

        if (wena) begin
            if (hit_gpio) gpio_d = wdata[15:0];
            if (hit_cmp)  cmp_d  = wdata;
            if (hit_cnt)  cnt_d  = wdata;
            if (hit_ctrl) begin
                en_d     = wdata[0];
                reload_d = wdata[2];
                if (wdata[1]) irq_d = 1'b0;
            end
        end

        if (match) irq_d = 1'b1;
    end

    // MMIO register bank with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q   <= 16'd0;
            cycle_q  <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            cnt_q    <= 32'd0;
            en_q     <= 1'b0;
            irq_q    <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            cycle_q  <= cycle_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
            reload_q <= reload_d;
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = irq_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM, GPIO, cycle counter, timer, decode
// errors and asynchronous reset, all against hand-computed values.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rena = 1'b0;
    logic        wena = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [15:0] gpio_out;
    logic        timer_irq;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] GPIO  = 32'h1002_0000;
    localparam logic [31:0] CYC   = 32'h1002_0004;
    localparam logic [31:0] CMP   = 32'h1002_0008;
    localparam logic [31:0] CTRL  = 32'h1002_000C;
    localparam logic [31:0] CNT   = 32'h1002_0010;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst), .rena(rena), .wena(wena), .addr(addr),
        .wdata(wdata), .rdata(rdata), .gpio_out(gpio_out),
        .timer_irq(timer_irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store commits on the next rising edge; returns just after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wena = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wena = 1'b0;
    endtask

    // Combinational load, taken away from any clock edge.
    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        rena = 1'b1; addr = a;
        #1;
        d = rdata; e = bus_err;
        rena = 1'b0;
    endtask

    initial begin
        logic [31:0] v, c0;
        logic        e;

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_gpio", {16'd0, gpio_out}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(CMP, v, e);  chk("rst_cmp", v, 32'hFFFF_FFFF);
        rd(CTRL, v, e); chk("rst_ctrl", v, 32'd0);
        rd(CNT, v, e);  chk("rst_cnt", v, 32'd0);
        rd(CYC, v, e);  chk("rst_cycle", v, 32'd0);
        @(negedge clk); rst = 1'b0;

        // 1. RAM store/load with byte-offset aliasing.
        wr(32'h1001_0004, 32'hA5A5_0001);
        rd(32'h1001_0004, v, e); chk("ram_ld4", v, 32'hA5A5_0001);
        chk("ram_err", {31'd0, e}, 32'd0);
        rd(32'h1001_0007, v, e); chk("ram_ld7", v, 32'hA5A5_0001);
        rd(32'h1001_2004, v, e); chk("ram_alias", v, 32'hA5A5_0001);

        // Load during a same-cycle store shows the old word.
        wr(32'h1001_0008, 32'h1111_1111);
        @(negedge clk);
        rena = 1'b1; wena = 1'b1; addr = 32'h1001_0008; wdata = 32'h2222_2222;
        #1; chk("ram_rw_old", rdata, 32'h1111_1111);
        @(posedge clk); #1; rena = 1'b0; wena = 1'b0;
        rd(32'h1001_0008, v, e); chk("ram_rw_new", v, 32'h2222_2222);

        // 2. Timer with reload.
        wr(CMP, 32'd3);
        wr(CNT, 32'd0);
        wr(CTRL, 32'b101);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("irq_e%0d", i), {31'd0, timer_irq}, {31'd0, (i == 4)});
        end
        rd(CNT, v, e); chk("reload_cnt0", v, 32'd0);
        @(posedge clk); #1;
        rd(CNT, v, e); chk("reload_cnt1", v, 32'd1);

        // 3. Timer one-shot.
        wr(CTRL, 32'b010);
        chk("irq_clr_a", {31'd0, timer_irq}, 32'd0);
        wr(CNT, 32'd0);
        wr(CTRL, 32'b001);
        repeat (6) @(posedge clk);
        #1;
        rd(CTRL, v, e); chk("oneshot_ctrl", v, 32'b010);
        rd(CNT, v, e);  chk("oneshot_cnt", v, 32'd3);
        chk("oneshot_irq", {31'd0, timer_irq}, 32'd1);
        wr(CTRL, 32'b010);
        chk("irq_w1c", {31'd0, timer_irq}, 32'd0);

        // 4. GPIO and read-only cycle counter.
        wr(GPIO, 32'h1234_ABCD);
        chk("gpio_out", {16'd0, gpio_out}, 32'h0000_ABCD);
        rd(GPIO, v, e); chk("gpio_rd", v, 32'h0000_ABCD);
        rd(CYC, c0, e);
        wr(CYC, 32'd0);
        rd(CYC, v, e); chk("cycle_ro", v, c0 + 32'd1);

        // 5. Undecoded accesses.
        rd(32'h2000_0000, v, e);
        chk("ud_rd0", v, 32'd0); chk("ud_err0", {31'd0, e}, 32'd1);
        rd(32'h1002_0020, v, e);
        chk("ud_rd1", v, 32'd0); chk("ud_err1", {31'd0, e}, 32'd1);
        wr(32'h1002_0020, 32'h0000_5555);
        chk("ud_gpio", {16'd0, gpio_out}, 32'h0000_ABCD);
        rd(CMP, v, e); chk("ud_cmp", v, 32'd3);

        // 6. Asynchronous reset mid-count.
        wr(CMP, 32'd10);
        wr(CNT, 32'd0);
        wr(CTRL, 32'b001);
        repeat (2) @(posedge clk);
        #1;
        rd(CNT, v, e); chk("pre_rst_cnt", v, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_gpio", {16'd0, gpio_out}, 32'd0);
        rd(CNT, v, e);  chk("arst_cnt", v, 32'd0);
        rd(CMP, v, e);  chk("arst_cmp", v, 32'hFFFF_FFFF);
        rd(CTRL, v, e); chk("arst_ctrl", v, 32'd0);
        rd(CYC, v, e);  chk("arst_cycle", v, 32'd0);
        @(negedge clk); rst = 1'b0;
        rd(32'h1001_0004, v, e); chk("ram_keep", v, 32'hA5A5_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
